// File: rtl/wb_pci_initiator_pkg.sv
// Shared PCI definitions used by the initiator and the PCI target:
// memory command codes, FSM state encodings and termination codes.
package wb_pci_initiator_pkg;

  localparam logic [3:0] PCI_CMD_MEMREAD  = 4'b0110;
  localparam logic [3:0] PCI_CMD_MEMWRITE = 4'b0111;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_ADDR = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_TURN = 3'd4;

  localparam logic [1:0] TERM_ACK = 2'd0;
  localparam logic [1:0] TERM_RTY = 2'd1;
  localparam logic [1:0] TERM_ERR = 2'd2;

  function automatic logic [3:0] pci_mem_cmd(input logic write);
    return write ? PCI_CMD_MEMWRITE : PCI_CMD_MEMREAD;
  endfunction

endpackage

// File: rtl/wb_pci_initiator.sv
// Wishbone classic slave to PCI single-data-phase memory initiator.
// Bus outputs are decoded from the state register so reset releases them at once.
module wb_pci_initiator
  import wb_pci_initiator_pkg::*;
#(
  parameter int WB_ADDR        = 30,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic               pci_clk_i,
  input  logic               pci_rst_ni,
  output logic               pci_req_no,
  input  logic               pci_gnt_ni,
  input  logic               pci_frame_ni,
  input  logic               pci_irdy_ni,
  input  logic               pci_devsel_ni,
  input  logic               pci_trdy_ni,
  input  logic               pci_stop_ni,
  output logic               pci_frame_no,
  output logic               pci_irdy_no,
  output logic               pci_ctl_oe_o,
  input  logic [31:0]        pci_ad_i,
  output logic [31:0]        pci_ad_o,
  output logic               pci_ad_oe_o,
  output logic [3:0]         pci_cbe_no,
  output logic               pci_cbe_oe_o,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [WB_ADDR-1:0] wb_adr_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        wb_dat_o,
  output logic               wb_ack_o,
  output logic               wb_rty_o,
  output logic               wb_err_o
);

  localparam int CW = $clog2(DEVSEL_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(DEVSEL_TIMEOUT - 1);

  logic [2:0]         state;
  logic [WB_ADDR-1:0] adr;
  logic [31:0]        dat;
  logic [3:0]         sel;
  logic               we;
  logic [1:0]         term;
  logic [CW-1:0]      devsel_cnt;
  logic               devsel_seen;
  logic [31:0]        rd_dat;
  logic               turn_q;
  logic               stb_q;
  logic               accept;
  logic               bus_idle;
  logic [31:0]        pci_addr;

  assign bus_idle = pci_frame_ni & pci_irdy_ni;
  assign pci_addr = 32'({adr, 2'b00});
  // A strobe still high right after TURN belongs to the request just terminated.
  assign accept   = wb_cyc_i & wb_stb_i & ~(turn_q & stb_q);
  assign wb_dat_o = rd_dat;

  always_ff @(posedge pci_clk_i or negedge pci_rst_ni) begin
    if (!pci_rst_ni) begin
      state       <= ST_IDLE;
      adr         <= '0;
      dat         <= '0;
      sel         <= '0;
      we          <= 1'b0;
      term        <= TERM_ACK;
      devsel_cnt  <= '0;
      devsel_seen <= 1'b0;
      rd_dat      <= '0;
      turn_q      <= 1'b0;
      stb_q       <= 1'b0;
    end else begin
      turn_q <= (state == ST_TURN);
      stb_q  <= wb_stb_i;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            adr   <= wb_adr_i;
            dat   <= wb_dat_i;
            sel   <= wb_sel_i;
            we    <= wb_we_i;
            state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (!pci_gnt_ni && bus_idle) state <= ST_ADDR;
        end
        ST_ADDR: begin
          devsel_cnt  <= '0;
          devsel_seen <= 1'b0;
          state       <= ST_DATA;
        end
        ST_DATA: begin
          if (!pci_devsel_ni) devsel_seen <= 1'b1;
          if (!pci_devsel_ni && !pci_trdy_ni) begin
            // Disconnect-with-data (STOP# together with TRDY#) is still a success.
            term  <= TERM_ACK;
            if (!we) rd_dat <= pci_ad_i;
            state <= ST_TURN;
          end else if (!pci_devsel_ni && !pci_stop_ni) begin
            term  <= TERM_RTY;
            state <= ST_TURN;
          end else if (pci_devsel_ni && !pci_stop_ni) begin
            term  <= TERM_ERR;
            state <= ST_TURN;
          end else if (pci_devsel_ni && !devsel_seen) begin
            if (devsel_cnt == TIMEOUT_LAST) begin
              term  <= TERM_ERR;
              state <= ST_TURN;
            end else begin
              devsel_cnt <= devsel_cnt + 1'b1;
            end
          end
        end
        ST_TURN: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pci_req_no   = 1'b1;
    pci_frame_no = 1'b1;
    pci_irdy_no  = 1'b1;
    pci_ctl_oe_o = 1'b0;
    pci_ad_o     = '0;
    pci_ad_oe_o  = 1'b0;
    pci_cbe_no   = 4'hf;
    pci_cbe_oe_o = 1'b0;
    wb_ack_o     = 1'b0;
    wb_rty_o     = 1'b0;
    wb_err_o     = 1'b0;
    case (state)
      ST_REQ: pci_req_no = 1'b0;
      ST_ADDR: begin
        pci_frame_no = 1'b0;
        pci_ctl_oe_o = 1'b1;
        pci_ad_o     = pci_addr;
        pci_ad_oe_o  = 1'b1;
        pci_cbe_no   = pci_mem_cmd(we);
        pci_cbe_oe_o = 1'b1;
      end
      ST_DATA: begin
        pci_irdy_no  = 1'b0;
        pci_ctl_oe_o = 1'b1;
        pci_ad_o     = we ? dat : 32'h0;
        pci_ad_oe_o  = we;
        pci_cbe_no   = ~sel;
        pci_cbe_oe_o = 1'b1;
      end
      ST_TURN: begin
        pci_ctl_oe_o = 1'b1;
        // An abandoned Wishbone cycle still finishes on PCI, silently.
        if (wb_cyc_i) begin
          wb_ack_o = (term == TERM_ACK);
          wb_rty_o = (term == TERM_RTY);
          wb_err_o = (term == TERM_ERR);
        end
      end
      default: ;
    endcase
  end

endmodule
